frame_tile_scheduler: RTL and testbench
=======================================

FRAME_TILE_SCHEDULER -- requirements
Module: frame_tile_scheduler

Interface
REQ-001 Parameter TILE_W, default 64: nominal tile width in pixels.
REQ-002 Parameter TILE_H, default 64: nominal tile height in pixels.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: maximum WAIT cycles per tile before error.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-high.
REQ-006 frame_start  input  1  single-cycle request to decode one frame.
REQ-007 frame_width  input  16  frame width in pixels, sampled on accepted frame_start.
REQ-008 frame_height  input  16  frame height in pixels, sampled on accepted frame_start.
REQ-009 tile_start  output  1  single-cycle launch pulse to the tile decoder.
REQ-010 tile_x, tile_y  output  16 each  pixel origin of the current tile.
REQ-011 tile_w, tile_h  output  16 each  clipped size of the current tile.
REQ-012 tile_done  input  1  completion pulse from the tile decoder.
REQ-013 busy  output  1  high from accepted frame_start until DONE or ERR.
REQ-014 frame_done  output  1  single-cycle pulse after the last tile completes.
REQ-015 error  output  1  sticky fault flag.
REQ-016 tile_count  output  16  tiles completed in the current frame.

Function
REQ-017 States: IDLE, LAUNCH, WAIT, ADVANCE, DONE, ERR; all outputs registered.
REQ-018 IDLE: frame_start with both dimensions nonzero latches dimensions, sets tile_x=tile_y=0, clears tile_count and error, goes to LAUNCH.
REQ-019 IDLE: frame_start with either dimension zero goes to ERR; no tile_start issued.
REQ-020 LAUNCH: tile_start high for exactly this one cycle, then WAIT.
REQ-021 tile_w = min(TILE_W, width - tile_x); tile_h = min(TILE_H, height - tile_y); 16-bit unsigned, stable from LAUNCH until ADVANCE.
REQ-022 WAIT: tile_done goes to ADVANCE and increments tile_count; the timeout counter restarts at 0 on entry.
REQ-023 WAIT: TIMEOUT_CYCLES consecutive cycles without tile_done goes to ERR.
REQ-024 ADVANCE, raster order:
  - tile_x + TILE_W < width: tile_x += TILE_W, then LAUNCH.
  - else if tile_y + TILE_H < height: tile_x = 0, tile_y += TILE_H, then LAUNCH.
  - else: DONE.
REQ-025 Comparisons in REQ-024 use 17-bit sums, so no wrap at 65535.
REQ-026 DONE: frame_done high for one cycle, busy low, then IDLE.
REQ-027 ERR: error set, busy low, one cycle, then IDLE; error holds until the next accepted frame_start.
REQ-028 frame_start outside IDLE is ignored; tile_done outside WAIT is ignored.
REQ-029 Timing:
  - frame_start at edge k: tile_start high in cycle k+1.
  - tile_done at edge m: next tile_start in cycle m+2, or frame_done in cycle m+2.
REQ-030 tile_count holds its final value after DONE or ERR until the next accepted frame_start.

Reset
REQ-031 When rst_n is asserted, the block is asynchronously forced to IDLE, even mid-frame.
REQ-032 During reset, all outputs, the timeout counter and the latched dimensions are 0.
REQ-033 First frame_start accepted on the first rising edge after rst_n deasserts.

Verification
REQ-034 64x64 frame, tile_done 5 cycles after each tile_start -> one tile (0,0,64,64), frame_done once, tile_count=1.
REQ-035 130x70 frame -> 6 tiles in order:
  - (0,0,64,64), (64,0,64,64), (128,0,2,64)
  - (0,64,64,6), (64,64,64,6), (128,64,2,6)
  - tile_count=6 at frame_done.
REQ-036 width=0 -> error=1 next cycle; no tile_start, no frame_done; error clears on next valid frame_start.
REQ-037 tile_done withheld -> ERR exactly TIMEOUT_CYCLES cycles after WAIT entry; error=1, busy=0.
REQ-038 rst_n asserted during WAIT of tile 3 -> all outputs 0 immediately; new frame after release restarts at (0,0).
REQ-039 frame_start pulsed while busy, and stray tile_done while in IDLE -> both ignored; tile order and count unchanged.

Source files
------------

// File: rtl/frame_tile_scheduler.sv
// ============================================================================
// Module      : frame_tile_scheduler
// Description : Walks a frame in raster order of clipped tiles, launching one
//               tile decode at a time with a per-tile completion timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_tile_scheduler #(
    parameter int TILE_W         = 64,
    parameter int TILE_H         = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [15:0] frame_width,
    input  logic [15:0] frame_height,
    output logic        tile_start,
    output logic [15:0] tile_x,
    output logic [15:0] tile_y,
    output logic [15:0] tile_w,
    output logic [15:0] tile_h,
    input  logic        tile_done,
    output logic        busy,
    output logic        frame_done,
    output logic        error,
    output logic [15:0] tile_count
);

    localparam int               TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]      STEP_X   = 17'(TILE_W);
    localparam logic [16:0]      STEP_Y   = 17'(TILE_H);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LAUNCH  = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_ADVANCE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [15:0]      width_q, width_d;
    logic [15:0]      height_q, height_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [15:0]      tile_x_q, tile_x_d;
    logic [15:0]      tile_y_q, tile_y_d;
    logic [15:0]      tile_w_q, tile_w_d;
    logic [15:0]      tile_h_q, tile_h_d;
    logic [15:0]      tile_count_q, tile_count_d;
    logic             tile_start_q, tile_start_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             error_q, error_d;

    logic             w_dims_ok;
    logic             w_accept;
    logic             w_x_more;
    logic             w_y_more;
    logic [15:0]      w_rem_x;
    logic [15:0]      w_rem_y;

    assign w_dims_ok = (frame_width != 16'd0) && (frame_height != 16'd0);
    assign w_accept  = (state_q == S_IDLE) && frame_start && w_dims_ok;
    // 17-bit sums so a tile ending at the 16-bit limit cannot wrap to "more"
    assign w_x_more  = ({1'b0, tile_x_q} + STEP_X) < {1'b0, width_q};
    assign w_y_more  = ({1'b0, tile_y_q} + STEP_Y) < {1'b0, height_q};

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= S_IDLE;
            width_q      <= '0;
            height_q     <= '0;
            timer_q      <= '0;
            tile_x_q     <= '0;
            tile_y_q     <= '0;
            tile_w_q     <= '0;
            tile_h_q     <= '0;
            tile_count_q <= '0;
            tile_start_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            timer_q      <= timer_d;
            tile_x_q     <= tile_x_d;
            tile_y_q     <= tile_y_d;
            tile_w_q     <= tile_w_d;
            tile_h_q     <= tile_h_d;
            tile_count_q <= tile_count_d;
            tile_start_q <= tile_start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = w_dims_ok ? S_LAUNCH : S_ERR;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (tile_done) begin
                    state_d = S_ADVANCE;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_ADVANCE: state_d = (w_x_more || w_y_more) ? S_LAUNCH : S_DONE;
            S_DONE:    state_d = S_IDLE;
            S_ERR:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it.
    always_comb begin
        width_d      = w_accept ? frame_width  : width_q;
        height_d     = w_accept ? frame_height : height_q;
        tile_x_d     = tile_x_q;
        tile_y_d     = tile_y_q;
        tile_count_d = tile_count_q;
        error_d      = error_q;

        if (w_accept) begin
            tile_x_d     = '0;
            tile_y_d     = '0;
            tile_count_d = '0;
        end else if (state_q == S_ADVANCE) begin
            if (w_x_more) begin
                tile_x_d = tile_x_q + STEP_X[15:0];
            end else if (w_y_more) begin
                tile_x_d = '0;
                tile_y_d = tile_y_q + STEP_Y[15:0];
            end
        end else if ((state_q == S_WAIT) && tile_done) begin
            tile_count_d = tile_count_q + 16'd1;
        end

        w_rem_x  = width_d - tile_x_d;
        w_rem_y  = height_d - tile_y_d;
        tile_w_d = ({1'b0, w_rem_x} > STEP_X) ? STEP_X[15:0] : w_rem_x;
        tile_h_d = ({1'b0, w_rem_y} > STEP_Y) ? STEP_Y[15:0] : w_rem_y;

        timer_d = ((state_q == S_WAIT) && (state_d == S_WAIT)) ? timer_q + 1'b1 : '0;

        if (w_accept) begin
            error_d = 1'b0;
        end else if (state_d == S_ERR) begin
            error_d = 1'b1;
        end

        tile_start_d = (state_d == S_LAUNCH);
        busy_d       = (state_d == S_LAUNCH) || (state_d == S_WAIT) || (state_d == S_ADVANCE);
        frame_done_d = (state_d == S_DONE);
    end

    assign tile_start = tile_start_q;
    assign tile_x     = tile_x_q;
    assign tile_y     = tile_y_q;
    assign tile_w     = tile_w_q;
    assign tile_h     = tile_h_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign error      = error_q;
    assign tile_count = tile_count_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_tile_scheduler.sv
// ============================================================================
// Module      : tb_frame_tile_scheduler
// Description : Randomized and directed bench with a timing-rule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_tile_scheduler;

    localparam int TW = 64;
    localparam int TH = 64;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_start = 1'b0;
    logic        tile_done = 1'b0;
    logic [15:0] frame_width = '0;
    logic [15:0] frame_height = '0;
    logic        tile_start, busy, frame_done, error;
    logic [15:0] tile_x, tile_y, tile_w, tile_h, tile_count;

    always #5 clk = ~clk;

    frame_tile_scheduler #(.TILE_W(TW), .TILE_H(TH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .frame_width(frame_width), .frame_height(frame_height),
        .tile_start(tile_start), .tile_x(tile_x), .tile_y(tile_y),
        .tile_w(tile_w), .tile_h(tile_h), .tile_done(tile_done),
        .busy(busy), .frame_done(frame_done), .error(error), .tile_count(tile_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;

    function automatic void chk(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endfunction

    // Reference model: edge-indexed events derived from the frame timing rules.
    bit m_active = 0, m_waiting = 0, m_err = 0, m_end_done = 0, m_next_done = 0;
    int m_launch_edge = 0, m_end_edge = -100, m_next_edge = 0;
    int m_count = 0, m_idx = 0, m_ntiles = 0, m_w = 0, m_h = 0;

    function automatic void tile_geom(input int idx, output int x, output int y,
                                      output int w, output int h);
        int cols;
        cols = (m_w + TW - 1) / TW;
        x = (idx % cols) * TW;
        y = (idx / cols) * TH;
        w = (m_w - x < TW) ? m_w - x : TW;
        h = (m_h - y < TH) ? m_h - y : TH;
    endfunction

    always @(posedge clk) begin
        edge_no++;
        if (rst_n) begin
            m_active = 0; m_waiting = 0; m_err = 0; m_count = 0; m_end_edge = -100;
        end else if (m_active) begin
            if (!m_waiting) begin
                if (edge_no == m_next_edge) begin
                    if (m_next_done) begin
                        m_active = 0; m_end_edge = edge_no; m_end_done = 1;
                    end else begin
                        m_idx++; m_launch_edge = edge_no; m_waiting = 1;
                    end
                end
            end else if (edge_no >= m_launch_edge + 2) begin
                if (tile_done) begin
                    m_count++; m_waiting = 0; m_next_edge = edge_no + 1;
                    m_next_done = (m_idx + 1 == m_ntiles);
                end else if (edge_no == m_launch_edge + TO + 1) begin
                    m_active = 0; m_waiting = 0; m_end_edge = edge_no;
                    m_end_done = 0; m_err = 1;
                end
            end
        end else if (frame_start && (m_end_edge != edge_no - 1)) begin
            if (frame_width == 0 || frame_height == 0) begin
                m_err = 1; m_end_edge = edge_no; m_end_done = 0;
            end else begin
                m_active = 1; m_waiting = 1; m_err = 0; m_count = 0; m_idx = 0;
                m_w = int'(frame_width); m_h = int'(frame_height);
                m_ntiles = ((m_w + TW - 1) / TW) * ((m_h + TH - 1) / TH);
                m_launch_edge = edge_no;
            end
        end
    end

    logic [63:0] log_q[$];
    int fd_cnt = 0, err_edge = 0, last_launch = 0;
    bit err_prev = 0;

    always @(negedge clk) begin
        int ex, ey, ew, eh;
        if (rst_n) begin
            chk("rst_outputs", {tile_start, busy, frame_done, error}, 0);
            chk("rst_geometry", {tile_x, tile_y, tile_w, tile_h}, 0);
            chk("rst_count", tile_count, 0);
            err_prev = 0;
        end else begin
            chk("tile_start", tile_start, (m_active && m_launch_edge == edge_no) ? 1 : 0);
            chk("busy", busy, m_active);
            chk("frame_done", frame_done, (m_end_edge == edge_no && m_end_done) ? 1 : 0);
            chk("error", error, m_err);
            chk("tile_count", tile_count, m_count);
            if (m_active) begin
                tile_geom(m_idx, ex, ey, ew, eh);
                chk("tile_x", tile_x, ex);
                chk("tile_y", tile_y, ey);
                chk("tile_w", tile_w, ew);
                chk("tile_h", tile_h, eh);
            end
            if (tile_start) begin
                log_q.push_back({tile_x, tile_y, tile_w, tile_h});
                last_launch = edge_no;
            end
            if (frame_done) fd_cnt++;
            if (error && !err_prev) err_edge = edge_no;
            err_prev = error;
        end
    end

    // Tile decoder stand-in: 1 = fixed delay after tile_start, 2 = random pulses.
    int td_mode = 0, td_delay = 5, td_cnt = 0;
    always @(posedge clk) begin
        #1;
        tile_done = 1'b0;
        if (rst_n) begin
            td_cnt = 0;
        end else if (td_mode == 1) begin
            if (tile_start) begin
                td_cnt = td_delay;
            end else if (td_cnt > 0) begin
                td_cnt--;
                tile_done = (td_cnt == 0);
            end
        end else if (td_mode == 2) begin
            tile_done = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic start_frame(input int w, input int h);
        @(posedge clk);
        #1;
        frame_width  = 16'(w);
        frame_height = 16'(h);
        frame_start  = 1'b1;
        @(posedge clk);
        #1;
        frame_start  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (m_active && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (m_active) begin
            n_checks++; n_fail++;
            $display("FAIL wait_idle: frame still active after %0d cycles, expected idle", budget);
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    logic [63:0] exp6 [6];

    initial begin
        int n;
        exp6[0] = {16'd0,   16'd0,  16'd64, 16'd64};
        exp6[1] = {16'd64,  16'd0,  16'd64, 16'd64};
        exp6[2] = {16'd128, 16'd0,  16'd2,  16'd64};
        exp6[3] = {16'd0,   16'd64, 16'd64, 16'd6};
        exp6[4] = {16'd64,  16'd64, 16'd64, 16'd6};
        exp6[5] = {16'd128, 16'd64, 16'd2,  16'd6};

        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        td_mode = 1;

        // single full tile
        log_q.delete(); fd_cnt = 0;
        start_frame(64, 64);
        wait_idle(200);
        chk("r034_ntiles", log_q.size(), 1);
        if (log_q.size() > 0) chk("r034_tile", log_q[0], {16'd0, 16'd0, 16'd64, 16'd64});
        chk("r034_frame_done", fd_cnt, 1);
        chk("r034_count", tile_count, 1);

        // clipped 130x70, with frame_start while busy and stray tile_done in idle
        log_q.delete(); fd_cnt = 0;
        start_frame(130, 70);
        repeat (12) @(posedge clk);
        start_frame(20, 20);
        wait_idle(300);
        td_mode = 2;
        repeat (8) @(posedge clk);
        td_mode = 1;
        repeat (2) @(posedge clk);
        chk("r035_ntiles", log_q.size(), 6);
        for (int i = 0; i < 6 && i < log_q.size(); i++) chk("r035_tile", log_q[i], exp6[i]);
        chk("r035_count", tile_count, 6);
        chk("r035_frame_done", fd_cnt, 1);

        // zero width
        log_q.delete(); fd_cnt = 0;
        start_frame(0, 50);
        chk("r036_error_next", error, 1);
        chk("r036_busy", busy, 0);
        repeat (5) @(posedge clk);
        #2;
        chk("r036_no_tiles", log_q.size(), 0);
        chk("r036_no_done", fd_cnt, 0);
        chk("r036_sticky", error, 1);
        start_frame(10, 10);
        chk("r036_clear", error, 0);
        wait_idle(100);
        if (log_q.size() > 0) chk("r036_tile", log_q[0], {16'd0, 16'd0, 16'd10, 16'd10});

        // timeout
        td_mode = 0;
        log_q.delete();
        start_frame(64, 64);
        wait_idle(100);
        chk("r037_latency", err_edge - last_launch, TO + 1);
        chk("r037_error", error, 1);
        chk("r037_busy", busy, 0);

        // asynchronous reset during WAIT of tile 3
        td_mode = 1;
        log_q.delete();
        start_frame(200, 64);
        n = 0;
        while (log_q.size() < 3 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("r038_reach_tile3", log_q.size(), 3);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("r038_flags", {tile_start, busy, frame_done, error}, 0);
        chk("r038_geometry", {tile_x, tile_y, tile_w, tile_h}, 0);
        chk("r038_count", tile_count, 0);
        repeat (2) @(negedge clk);
        #1;
        log_q.delete();
        frame_width = 16'd200; frame_height = 16'd64; frame_start = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1 frame_start = 1'b0;
        chk("r033_first_start", tile_start, 1);
        chk("r038_restart_x", tile_x, 0);
        chk("r038_restart_y", tile_y, 0);
        wait_idle(200);
        chk("r038_ntiles", log_q.size(), 4);
        if (log_q.size() == 4) chk("r038_last", log_q[3], {16'd192, 16'd0, 16'd8, 16'd64});
        chk("r038_count", tile_count, 4);

        // 16-bit limit: last column ends exactly at 65535
        log_q.delete();
        start_frame(65535, 1);
        wait_idle(20000);
        chk("wrap_ntiles", log_q.size(), 1024);
        if (log_q.size() == 1024) chk("wrap_last", log_q[1023], {16'd65472, 16'd0, 16'd63, 16'd1});
        chk("wrap_count", tile_count, 1024);

        // randomized traffic
        td_mode = 2;
        repeat (3000) begin
            @(posedge clk);
            #1;
            frame_start  = ($urandom_range(0, 15) == 0);
            frame_width  = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom_range(1, 200));
            frame_height = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom_range(1, 200));
        end
        frame_start = 1'b0;
        td_mode = 1;
        wait_idle(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        n_fail++;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
